pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_gen_redirect_arb.sv | 39 +++
 rtl/pc_gen.sv | 102 ++++++++++
 tb/tb_pc_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Holds the FSM state encoding, the RV32 word type and the alignment masks.
package pc_gen_pkg;

    typedef logic [31:0] rv32_word_t;

    typedef enum logic [1:0] {
        PC_BOOT   = 2'd0,
        PC_RUN    = 2'd1,
        PC_BUBBLE = 2'd2
    } pc_state_t;

    // The low PC bits that must be zero for each instruction alignment.
    localparam logic [1:0] ALIGN_MASK_HALF = 2'b01;
    localparam logic [1:0] ALIGN_MASK_WORD = 2'b11;

    function automatic logic [1:0] align_mask(input int ialign);
        return (ialign == 2) ? ALIGN_MASK_HALF : ALIGN_MASK_WORD;
    endfunction

endpackage

// File: rtl/pc_gen_redirect_arb.sv
// Redirect arbiter: picks one of trap/mret/branch and checks its alignment.
// A trap target is force-aligned, so a trap is never reported as misaligned.
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret_en,
    input  logic [XLEN-1:0] mepc,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_target,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);
    localparam logic [1:0] LOW_MASK = align_mask(IALIGN);

    always_comb begin
        redirect   = 1'b0;
        target     = branch_target;
        misaligned = 1'b0;
        if (trap_en) begin
            target      = trap_vector;
            target[1:0] = trap_vector[1:0] & ~LOW_MASK;
            redirect    = 1'b1;
        end else if (mret_en) begin
            target     = mepc;
            misaligned = |(mepc[1:0] & LOW_MASK);
            redirect   = ~misaligned;
        end else if (branch_en) begin
            misaligned = |(branch_target[1:0] & LOW_MASK);
            redirect   = ~misaligned;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, sequential advance and redirects.
// A redirect costs one bubble cycle; a misaligned one is dropped and flagged.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              IALIGN       = 4,
    parameter int              BOOT_DELAY   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            inc_half,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_target,
    input  logic            mret_en,
    input  logic [XLEN-1:0] mepc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            misaligned,
    output logic [XLEN-1:0] misaligned_addr
);
    // With XLEN=32 the pc register is an rv32_word_t.
    pc_state_t       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0] step;

    logic            arb_redirect;
    logic [XLEN-1:0] arb_target;
    logic            arb_mis;

    pc_redirect_arb #(.XLEN(XLEN), .IALIGN(IALIGN)) u_arb (
        .trap_en       (trap_en),
        .trap_vector   (trap_vector),
        .mret_en       (mret_en),
        .mepc          (mepc),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .redirect      (arb_redirect),
        .target        (arb_target),
        .misaligned    (arb_mis)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        maddr_d = maddr_q;
        step    = (IALIGN == 2 && inc_half) ? XLEN'(2) : XLEN'(4);
        case (state_q)
            PC_BOOT: begin
                if (cnt_q == 4'd0) state_d = PC_RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            PC_RUN, PC_BUBBLE: begin
                if (arb_redirect) begin
                    pc_d    = arb_target;
                    state_d = PC_BUBBLE;
                end else if (arb_mis) begin
                    // Dropped redirect also suppresses this cycle's advance.
                    mis_d   = 1'b1;
                    maddr_d = arb_target;
                end else if (state_q == PC_BUBBLE) begin
                    state_d = PC_RUN;
                end else if (fetch_ready && !stall) begin
                    pc_d = pc_q + step;
                end
            end
            default: state_d = PC_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PC_BOOT;
            cnt_q   <= 4'(BOOT_DELAY);
            pc_q    <= RESET_VECTOR;
            mis_q   <= 1'b0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            maddr_q <= maddr_d;
        end
    end

    assign pc              = pc_q;
    assign pc_valid        = (state_q == PC_RUN);
    assign misaligned      = mis_q;
    assign misaligned_addr = maddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a word-aligned instance (boot delay 2) and a
// half-word-aligned instance (boot delay 0) share the same stimulus.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, fetch_ready, inc_half;
    logic        branch_en, mret_en, trap_en;
    logic [31:0] branch_target, mepc, trap_vector;

    logic [31:0] pc4, maddr4, pc2, maddr2;
    logic        vld4, mis4, vld2, mis2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h8000_0000), .IALIGN(4), .BOOT_DELAY(2)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready), .inc_half(inc_half),
        .branch_en(branch_en), .branch_target(branch_target), .mret_en(mret_en), .mepc(mepc),
        .trap_en(trap_en), .trap_vector(trap_vector), .pc(pc4), .pc_valid(vld4),
        .misaligned(mis4), .misaligned_addr(maddr4)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(2), .BOOT_DELAY(0)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready), .inc_half(inc_half),
        .branch_en(branch_en), .branch_target(branch_target), .mret_en(mret_en), .mepc(mepc),
        .trap_en(trap_en), .trap_vector(trap_vector), .pc(pc2), .pc_valid(vld2),
        .misaligned(mis2), .misaligned_addr(maddr2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic branch_to(input logic [31:0] t);
        branch_en = 1'b1; branch_target = t;
        tick();
        branch_en = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (pc4 !== 32'h8000_0000 || vld4 !== 1'b0 || mis4 !== 1'b0 || maddr4 !== 32'h0)
            $display("FAIL reset_dut4: pc=%h vld=%b mis=%b maddr=%h, need 80000000/0/0/0", pc4, vld4, mis4, maddr4);
        else passed++;
        checks++;
        if (pc2 !== 32'h0 || vld2 !== 1'b0)
            $display("FAIL reset_dut2: pc=%h vld=%b, need 00000000/0", pc2, vld2);
        else passed++;
        @(negedge clk) rst = 1'b0;
        tick();
        checks++;
        if (vld4 !== 1'b0 || vld2 !== 1'b1 || pc2 !== 32'h0)
            $display("FAIL boot_edge1: vld4=%b vld2=%b pc2=%h, need 0/1/00000000", vld4, vld2, pc2);
        else passed++;
        tick();
        checks++;
        if (vld4 !== 1'b0 || pc2 !== 32'h4)
            $display("FAIL boot_edge2: vld4=%b pc2=%h, need 0/00000004", vld4, pc2);
        else passed++;
        tick();
        checks++;
        if (vld4 !== 1'b1 || pc4 !== 32'h8000_0000)
            $display("FAIL boot_edge3: vld=%b pc=%h, need 1/80000000", vld4, pc4);
        else passed++;
        tick();
        checks++;
        if (pc4 !== 32'h8000_0004) $display("FAIL seq_1: pc=%h, need 80000004", pc4);
        else passed++;
        tick();
        checks++;
        if (pc4 !== 32'h8000_0008) $display("FAIL seq_2: pc=%h, need 80000008", pc4);
        else passed++;
    endtask

    task automatic test_priority();
        branch_to(32'h100);
        tick();
        checks++;
        if (pc4 !== 32'h100 || vld4 !== 1'b1) $display("FAIL prio_setup: pc=%h vld=%b, need 00000100/1", pc4, vld4);
        else passed++;
        trap_en = 1'b1; trap_vector = 32'h203;
        branch_en = 1'b1; branch_target = 32'h400;
        tick();
        trap_en = 1'b0; branch_en = 1'b0;
        checks++;
        if (pc4 !== 32'h200 || vld4 !== 1'b0 || mis4 !== 1'b0)
            $display("FAIL prio_trap4: pc=%h vld=%b mis=%b, need 00000200/0/0", pc4, vld4, mis4);
        else passed++;
        checks++;
        if (pc2 !== 32'h202 || vld2 !== 1'b0 || mis2 !== 1'b0)
            $display("FAIL prio_trap2: pc=%h vld=%b mis=%b, need 00000202/0/0", pc2, vld2, mis2);
        else passed++;
        tick();
        checks++;
        if (pc4 !== 32'h200 || vld4 !== 1'b1) $display("FAIL prio_bubble_end: pc=%h vld=%b, need 00000200/1", pc4, vld4);
        else passed++;
    endtask

    task automatic test_misaligned();
        fetch_ready = 1'b0;
        branch_to(32'h102);
        checks++;
        if (pc4 !== 32'h200 || vld4 !== 1'b1 || mis4 !== 1'b1 || maddr4 !== 32'h102)
            $display("FAIL mis_flag4: pc=%h vld=%b mis=%b maddr=%h, need 00000200/1/1/00000102", pc4, vld4, mis4, maddr4);
        else passed++;
        checks++;
        if (pc2 !== 32'h102 || vld2 !== 1'b0 || mis2 !== 1'b0)
            $display("FAIL mis_ok2: pc=%h vld=%b mis=%b, need 00000102/0/0", pc2, vld2, mis2);
        else passed++;
        tick();
        checks++;
        if (mis4 !== 1'b0 || maddr4 !== 32'h102 || pc4 !== 32'h200)
            $display("FAIL mis_clear4: mis=%b maddr=%h pc=%h, need 0/00000102/00000200", mis4, maddr4, pc4);
        else passed++;
        checks++;
        if (pc2 !== 32'h102 || vld2 !== 1'b1) $display("FAIL mis_run2: pc=%h vld=%b, need 00000102/1", pc2, vld2);
        else passed++;
        mret_en = 1'b1; mepc = 32'h301;
        tick();
        mret_en = 1'b0;
        checks++;
        if (mis4 !== 1'b1 || maddr4 !== 32'h301 || mis2 !== 1'b1 || maddr2 !== 32'h301 || pc2 !== 32'h102)
            $display("FAIL mis_mret: mis4=%b maddr4=%h mis2=%b maddr2=%h pc2=%h, need 1/00000301/1/00000301/00000102", mis4, maddr4, mis2, maddr2, pc2);
        else passed++;
        fetch_ready = 1'b1;
    endtask

    task automatic test_stall();
        branch_to(32'h40);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc4 !== 32'h40 || vld4 !== 1'b1) $display("FAIL stall_hold%0d: pc=%h vld=%b, need 00000040/1", i, pc4, vld4);
            else passed++;
        end
        branch_to(32'h80);
        checks++;
        if (pc4 !== 32'h80 || vld4 !== 1'b0) $display("FAIL stall_branch: pc=%h vld=%b, need 00000080/0", pc4, vld4);
        else passed++;
        stall = 1'b0;
        tick();
        checks++;
        if (pc4 !== 32'h80 || vld4 !== 1'b1) $display("FAIL stall_resume: pc=%h vld=%b, need 00000080/1", pc4, vld4);
        else passed++;
    endtask

    task automatic test_wrap_half();
        branch_to(32'hFFFF_FFFC);
        tick();
        tick();
        checks++;
        if (pc4 !== 32'h0 || vld4 !== 1'b1) $display("FAIL wrap: pc=%h vld=%b, need 00000000/1", pc4, vld4);
        else passed++;
        inc_half = 1'b1;
        branch_to(32'h10);
        tick();
        tick();
        checks++;
        if (pc2 !== 32'h12) $display("FAIL half_inc2: pc=%h, need 00000012", pc2);
        else passed++;
        checks++;
        if (pc4 !== 32'h14) $display("FAIL half_ignored4: pc=%h, need 00000014", pc4);
        else passed++;
        inc_half = 1'b0;
    endtask

    task automatic test_reset_bubble();
        branch_to(32'h300);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pc4 !== 32'h8000_0000 || vld4 !== 1'b0 || pc2 !== 32'h0)
            $display("FAIL async_rst: pc4=%h vld4=%b pc2=%h, need 80000000/0/00000000", pc4, vld4, pc2);
        else passed++;
        @(negedge clk) rst = 1'b0;
        tick();
        tick();
        checks++;
        if (vld4 !== 1'b0 || pc4 !== 32'h8000_0000) $display("FAIL reboot_edge2: vld=%b pc=%h, need 0/80000000", vld4, pc4);
        else passed++;
        tick();
        checks++;
        if (vld4 !== 1'b1 || pc4 !== 32'h8000_0000) $display("FAIL reboot_edge3: vld=%b pc=%h, need 1/80000000", vld4, pc4);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; fetch_ready = 1'b1; inc_half = 1'b0;
        branch_en = 1'b0; mret_en = 1'b0; trap_en = 1'b0;
        branch_target = '0; mepc = '0; trap_vector = '0;
        test_reset();
        test_priority();
        test_misaligned();
        test_stall();
        test_wrap_half();
        test_reset_bubble();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
